// File: rtl/cpu_loader_pkg.sv
// Shared types and header field layout for the CPU program loader.
package cpu_loader_pkg;

    localparam int unsigned DEF_IMEM_DEPTH = 32;
    localparam int unsigned DEF_DMEM_DEPTH = 16;

    localparam int unsigned HDR_START_BIT = 15;
    localparam int unsigned HDR_NI_MSB    = 14;
    localparam int unsigned HDR_NI_LSB    = 10;
    localparam int unsigned HDR_ND_MSB    = 9;
    localparam int unsigned HDR_ND_LSB    = 5;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned LOAD_ADDR_W = 5;

    typedef enum logic [2:0] {
        StHdr,
        StRunlen,
        StInstr,
        StData,
        StSettle,
        StRun,
        StCapture,
        StDone
    } loader_state_e;

endpackage

// File: rtl/loader_run_timer.sv
// Loadable 16-bit down-counter that times the CPU run phase; saturates at zero.
module loader_run_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        dec,
    output logic        done
);

    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != 16'd0)) begin
            count_q <= count_q - 16'd1;
        end
    end

    assign done = (count_q == 16'd0);

endmodule

// File: rtl/cpu_program_loader.sv
// Loads a framed instruction/data stream into the CPU, runs it for R cycles
// and returns the captured CPU output word to the host.
module cpu_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter int unsigned DMEM_DEPTH = DEF_DMEM_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_data,
    output logic                   err,
    output logic                   cpu_reset,
    output logic [WORD_W-1:0]      cpu_input,
    output logic [LOAD_ADDR_W-1:0] load_address,
    output logic                   load,
    output logic                   is_instruction,
    input  logic [WORD_W-1:0]      cpu_output
);

    loader_state_e state_q, state_d;

    logic [4:0]             ni_m1_q, ni_m1_d;
    logic [4:0]             nd_q, nd_d;
    logic [4:0]             idx_q, idx_d;
    logic                   skip_run_q, skip_run_d;
    logic                   load_q, load_d;
    logic [WORD_W-1:0]      cpu_input_q, cpu_input_d;
    logic [LOAD_ADDR_W-1:0] load_address_q, load_address_d;
    logic                   is_instruction_q, is_instruction_d;
    logic                   err_q, err_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic [WORD_W-1:0]      out_data_q;

    logic       accept;
    logic       hdr_ok;
    logic [4:0] hdr_ni_m1;
    logic [4:0] hdr_nd;
    logic       capture;
    logic       timer_load;
    logic       timer_dec;
    logic       timer_done;

    assign in_ready  = !reset && (state_q inside {StHdr, StRunlen, StInstr, StData});
    assign accept    = in_valid && in_ready;
    assign hdr_ni_m1 = in_data[HDR_NI_MSB:HDR_NI_LSB];
    assign hdr_nd    = in_data[HDR_ND_MSB:HDR_ND_LSB];
    assign hdr_ok    = in_data[HDR_START_BIT]
                       && (32'(hdr_nd) <= DMEM_DEPTH)
                       && (32'(hdr_ni_m1) < IMEM_DEPTH);

    loader_run_timer u_run_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (in_data),
        .dec        (timer_dec),
        .done       (timer_done)
    );

    always_comb begin
        state_d          = state_q;
        ni_m1_d          = ni_m1_q;
        nd_d             = nd_q;
        idx_d            = idx_q;
        skip_run_d       = skip_run_q;
        load_d           = 1'b0;
        cpu_input_d      = cpu_input_q;
        load_address_d   = load_address_q;
        is_instruction_d = is_instruction_q;
        err_d            = 1'b0;
        capture          = 1'b0;
        timer_load       = 1'b0;
        timer_dec        = 1'b0;

        unique case (state_q)
            StHdr: begin
                if (accept) begin
                    if (hdr_ok) begin
                        ni_m1_d = hdr_ni_m1;
                        nd_d    = hdr_nd;
                        idx_d   = '0;
                        state_d = StRunlen;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRunlen: begin
                if (accept) begin
                    timer_load = 1'b1;
                    idx_d      = '0;
                    state_d    = StInstr;
                end
            end
            StInstr: begin
                if (accept) begin
                    load_d           = 1'b1;
                    cpu_input_d      = in_data;
                    load_address_d   = idx_q;
                    is_instruction_d = 1'b1;
                    if (idx_q == ni_m1_q) begin
                        idx_d   = '0;
                        state_d = (nd_q == 5'd0) ? StSettle : StData;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    load_d           = 1'b1;
                    cpu_input_d      = in_data;
                    load_address_d   = {1'b0, idx_q[3:0]};
                    is_instruction_d = 1'b0;
                    if (idx_q == nd_q - 5'd1) begin
                        idx_d   = '0;
                        state_d = StSettle;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            StSettle: begin
                // The first decrement happens here so RUN lasts exactly R cycles.
                skip_run_d = timer_done;
                timer_dec  = !timer_done;
                state_d    = timer_done ? StCapture : StRun;
            end
            StRun: begin
                if (timer_done) begin
                    capture = 1'b1;
                    state_d = StCapture;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            StCapture: begin
                capture = skip_run_q;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StHdr;
                end
            end
            default: state_d = StHdr;
        endcase

        cpu_reset_d = (state_d != StRun);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StHdr;
            ni_m1_q          <= '0;
            nd_q             <= '0;
            idx_q            <= '0;
            skip_run_q       <= 1'b0;
            load_q           <= 1'b0;
            cpu_input_q      <= '0;
            load_address_q   <= '0;
            is_instruction_q <= 1'b0;
            err_q            <= 1'b0;
            cpu_reset_q      <= 1'b1;
            out_data_q       <= '0;
        end else begin
            state_q          <= state_d;
            ni_m1_q          <= ni_m1_d;
            nd_q             <= nd_d;
            idx_q            <= idx_d;
            skip_run_q       <= skip_run_d;
            load_q           <= load_d;
            cpu_input_q      <= cpu_input_d;
            load_address_q   <= load_address_d;
            is_instruction_q <= is_instruction_d;
            err_q            <= err_d;
            cpu_reset_q      <= cpu_reset_d;
            if (capture) begin
                out_data_q <= cpu_output;
            end
        end
    end

    assign out_valid      = (state_q == StDone);
    assign out_data       = out_data_q;
    assign err            = err_q;
    assign cpu_reset      = cpu_reset_q;
    assign cpu_input      = cpu_input_q;
    assign load_address   = load_address_q;
    assign load           = load_q;
    assign is_instruction = is_instruction_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Scoreboard bench for cpu_program_loader: expected loads/results are queued by
// the stimulus and checked by an independent monitor.
module tb_cpu_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        err;
    logic        cpu_reset;
    logic [15:0] cpu_input;
    logic [4:0]  load_address;
    logic        load;
    logic        is_instruction;
    logic [15:0] cpu_output = 16'hC000;

    typedef struct {
        logic        is_i;
        logic [4:0]  addr;
        logic [15:0] data;
        int          gap;
    } ld_t;

    ld_t         exp_q[$];
    logic [15:0] res_q[$];
    logic [15:0] iw[32];
    logic [15:0] dw[16];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_load_cyc = 0;
    int low_cnt = 0;

    cpu_program_loader dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .err            (err),
        .cpu_reset      (cpu_reset),
        .cpu_input      (cpu_input),
        .load_address   (load_address),
        .load           (load),
        .is_instruction (is_instruction),
        .cpu_output     (cpu_output)
    );

    always #5 clk = ~clk;

    // CPU stub: constant while held in reset, counts up while running.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        cpu_output <= cpu_reset ? 16'hC000 : cpu_output + 16'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ld_t e;
        #1;
        if (load) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_load", 32'(load_address), 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("load_is_instruction", 32'(is_instruction), 32'(e.is_i));
                chk("load_address", 32'(load_address), 32'(e.addr));
                chk("load_data", 32'(cpu_input), 32'(e.data));
                if (e.gap != 0) chk("load_gap", cyc - last_load_cyc, e.gap);
            end
            last_load_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            if (res_q.size() == 0) chk("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
            else chk("out_data", 32'(out_data), 32'(res_q.pop_front()));
        end
        if (!cpu_reset) low_cnt++;
    end

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic send(input logic [15:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("in_ready_timeout", 32'(t), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_ld(input logic is_i, input int addr, input logic [15:0] d, input int gap);
        ld_t e;
        e.is_i = is_i;
        e.addr = 5'(addr);
        e.data = d;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic run_frame(input int ni, input int nd, input int r, input bit toggle,
                             input int hold, input logic [15:0] exp_out);
        int t = 0;
        res_q.push_back(exp_out);
        low_cnt = 0;
        send({1'b1, 5'(ni - 1), 5'(nd), 5'b0});
        send(16'(r));
        for (int k = 0; k < ni; k++) begin
            push_ld(1'b1, k, iw[k], (k == 0) ? 0 : (toggle ? 2 : 1));
            send(iw[k]);
            if (toggle && k < ni - 1) @(negedge clk);
        end
        for (int j = 0; j < nd; j++) begin
            push_ld(1'b0, j, dw[j], 1);
            send(dw[j]);
        end
        while (!out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid_latency", 32'(t), 32'(r + 2));
        chk("cpu_reset_low_cycles", 32'(low_cnt), 32'(r));
        for (int i = 0; i < hold; i++) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_handshake_in_ready", 32'(in_ready), 32'd1);
        chk("post_handshake_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_cpu_input", 32'(cpu_input), 32'd0);
        chk("rst_load_address", 32'(load_address), 32'd0);
        chk("rst_is_instruction", 32'(is_instruction), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    task automatic bad_header(input logic [15:0] h);
        send(h);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_stays_hdr", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("err_one_cycle", 32'(err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk_reset_outputs();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Header 0x8420: N_I=2, N_D=1, R=5.
        iw[0] = 16'h1234;
        iw[1] = 16'h5678;
        dw[0] = 16'h00AA;
        run_frame(2, 1, 5, 1'b0, 0, 16'hC004);

        bad_header(16'h0420);

        for (int k = 0; k < 4; k++) iw[k] = 16'hA000 + 16'(k);
        dw[0] = 16'h0D00;
        dw[1] = 16'h0D01;
        run_frame(4, 2, 3, 1'b1, 0, 16'hC002);

        bad_header(16'h8220);

        for (int k = 0; k < 3; k++) iw[k] = 16'h3000 + 16'(k * 3);
        run_frame(3, 0, 0, 1'b0, 0, 16'hC000);

        // Abandon a frame after its third instruction word.
        for (int k = 0; k < 4; k++) iw[k] = 16'h7700 + 16'(k);
        send({1'b1, 5'd3, 5'd1, 5'b0});
        send(16'd2);
        for (int k = 0; k < 3; k++) begin
            push_ld(1'b1, k, iw[k], (k == 0) ? 0 : 1);
            send(iw[k]);
        end
        reset = 1'b1;
        #1;
        chk("mid_reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk_reset_outputs();
        reset = 1'b0;
        @(negedge clk);
        chk("after_reset_in_ready", 32'(in_ready), 32'd1);

        iw[0] = 16'h4444;
        iw[1] = 16'h5555;
        dw[0] = 16'h0011;
        dw[1] = 16'h0022;
        run_frame(2, 2, 2, 1'b0, 4, 16'hC001);

        repeat (3) @(negedge clk);
        chk("loads_drained", 32'(exp_q.size()), 32'd0);
        chk("results_drained", 32'(res_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
